// File: rtl/bist_pkg.sv
// ------------------------------------------------------------------
// bist_pkg: shared widths, BIST constants, state encodings, helpers.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package bist_pkg;

  localparam int OP_W  = 8;
  localparam int Y_W   = 5;
  localparam int OUT_W = 13;

  localparam logic [7:0] LFSR_SEED_A = 8'hFF;
  localparam logic [7:0] LFSR_SEED_B = 8'hA5;
  // x^8+x^6+x^5+x^4+1 as a left-shifting Fibonacci register: taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS   = 8'b1011_1000;
  localparam logic [7:0] CRC_POLY    = 8'h07;
  localparam int         VEC_COUNT   = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CS_IDLE = 2'd0,
    CS_CBRT = 2'd1,
    CS_ADD  = 2'd2,
    CS_SQRT = 2'd3
  } core_state_e;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

  function automatic logic [7:0] crc8_fold(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/func_core.sv
// ------------------------------------------------------------------
// func_core: y = floor(sqrt(a + floor(cbrt(b)))), iterative, start/done.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module func_core
  import bist_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [OP_W-1:0] a_i,
  input  logic [OP_W-1:0] b_i,
  output logic            done_o,
  output logic [Y_W-1:0]  y_o
);

  core_state_e     state_q, state_d;
  logic [OP_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]      r_q, r_d, it_q, it_d;
  logic [9:0]      rad_q, rad_d;
  logic [7:0]      rem_q, rem_d;
  logic [Y_W-1:0]  root_q, root_d, y_q, y_d;
  logic            done_q, done_d;
  logic [8:0]      cube;
  logic [9:0]      rem_trial, trial;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    it_d      = it_q;
    rad_d     = rad_q;
    rem_d     = rem_q;
    root_d    = root_q;
    y_d       = y_q;
    done_d    = 1'b0;
    cube      = {6'd0, r_q} * {6'd0, r_q} * {6'd0, r_q};
    rem_trial = {rem_q, rad_q[9:8]};
    trial     = {3'd0, root_q, 2'b01};
    case (state_q)
      CS_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          r_d     = 3'd6;
          state_d = CS_CBRT;
        end
      end
      CS_CBRT: begin
        // r counts down from 6; the first r with r^3 <= b is the floor cube root
        if (({1'b0, b_q} >= cube) || (r_q == 3'd0)) state_d = CS_ADD;
        else                                         r_d     = r_q - 3'd1;
      end
      CS_ADD: begin
        rad_d   = {1'b0, {1'b0, a_q} + {6'd0, r_q}};
        rem_d   = '0;
        root_d  = '0;
        it_d    = '0;
        state_d = CS_SQRT;
      end
      CS_SQRT: begin
        if (rem_trial >= trial) begin
          rem_d  = 8'(rem_trial - trial);
          root_d = {root_q[Y_W-2:0], 1'b1};
        end else begin
          rem_d  = 8'(rem_trial);
          root_d = {root_q[Y_W-2:0], 1'b0};
        end
        rad_d = {rad_q[7:0], 2'b00};
        it_d  = it_q + 3'd1;
        if (it_q == 3'd4) begin
          y_d     = root_d;
          done_d  = 1'b1;
          state_d = CS_IDLE;
        end
      end
      default: state_d = CS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CS_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      it_q    <= '0;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      it_q    <= it_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  assign done_o = done_q;
  assign y_o    = y_q;

endmodule

`default_nettype wire

// File: rtl/bist_logic_unit.sv
// ------------------------------------------------------------------
// bist_logic_unit: edge detect, mode/FSM, LFSR stimulus and CRC signature.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module bist_logic_unit
  import bist_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [OP_W-1:0]  a_i,
  input  logic [OP_W-1:0]  b_i,
  input  logic             start_i,
  input  logic             test_button,
  output logic             busy_o,
  output logic [OUT_W-1:0] y_o
);

  localparam logic [7:0] VEC_LAST = 8'(VEC_COUNT - 1);

  state_e           state_q, state_d;
  logic             start_q, start_prev_q, btn_q, btn_prev_q;
  logic             mode_bist_q, mode_bist_d;
  logic [7:0]       lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [7:0]       crc_q, crc_d, vec_q, vec_d;
  logic [3:0]       bist_cnt_q, bist_cnt_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             start_edge, btn_edge;
  logic             core_start, core_done;
  logic [OP_W-1:0]  op_a, op_b;
  logic [Y_W-1:0]   core_y;
  logic [7:0]       crc_fold;

  assign start_edge = start_q & ~start_prev_q;
  assign btn_edge   = btn_q & ~btn_prev_q;

  func_core u_core (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(core_start),
    .a_i    (op_a),
    .b_i    (op_b),
    .done_o (core_done),
    .y_o    (core_y)
  );

  always_comb begin
    state_d     = state_q;
    mode_bist_d = mode_bist_q;
    lfsr_a_d    = lfsr_a_q;
    lfsr_b_d    = lfsr_b_q;
    crc_d       = crc_q;
    vec_d       = vec_q;
    bist_cnt_d  = bist_cnt_q;
    y_d         = y_q;
    core_start  = 1'b0;
    op_a        = a_i;
    op_b        = b_i;
    crc_fold    = crc8_fold(crc_q, {{(8-Y_W){1'b0}}, core_y});
    case (state_q)
      ST_IDLE: begin
        if (btn_edge) mode_bist_d = ~mode_bist_q;
        if (start_edge) begin
          core_start = 1'b1;
          state_d    = ST_CALC;
          if (mode_bist_q) begin
            op_a     = LFSR_SEED_A;
            op_b     = LFSR_SEED_B;
            lfsr_a_d = LFSR_SEED_A;
            lfsr_b_d = LFSR_SEED_B;
            crc_d    = 8'h00;
            vec_d    = 8'd0;
          end
        end
      end
      ST_CALC: begin
        if (core_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!mode_bist_q) begin
          y_d     = {{(OUT_W-Y_W){1'b0}}, core_y};
          state_d = ST_IDLE;
        end else begin
          crc_d = crc_fold;
          if (vec_q == VEC_LAST) begin
            bist_cnt_d = bist_cnt_q + 4'd1;
            y_d        = {bist_cnt_d, 1'b0, crc_fold};
            state_d    = ST_IDLE;
          end else begin
            // lfsr registers always hold the operands of the vector in flight
            lfsr_a_d   = lfsr_step(lfsr_a_q);
            lfsr_b_d   = lfsr_step(lfsr_b_q);
            op_a       = lfsr_a_d;
            op_b       = lfsr_b_d;
            core_start = 1'b1;
            vec_d      = vec_q + 8'd1;
            state_d    = ST_CALC;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      start_q      <= 1'b0;
      start_prev_q <= 1'b0;
      btn_q        <= 1'b0;
      btn_prev_q   <= 1'b0;
      mode_bist_q  <= 1'b0;
      lfsr_a_q     <= '0;
      lfsr_b_q     <= '0;
      crc_q        <= '0;
      vec_q        <= '0;
      bist_cnt_q   <= '0;
      y_q          <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_i;
      start_prev_q <= start_q;
      btn_q        <= test_button;
      btn_prev_q   <= btn_q;
      mode_bist_q  <= mode_bist_d;
      lfsr_a_q     <= lfsr_a_d;
      lfsr_b_q     <= lfsr_b_d;
      crc_q        <= crc_d;
      vec_q        <= vec_d;
      bist_cnt_q   <= bist_cnt_d;
      y_q          <= y_d;
    end
  end

  assign busy_o = (state_q != ST_IDLE);
  assign y_o    = y_q;

endmodule

`default_nettype wire

// File: tb/tb_bist_logic_unit.sv
// ------------------------------------------------------------------
// tb_bist_logic_unit: directed stimulus with a queue-based result scoreboard.
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_bist_logic_unit;

  logic        clk = 1'b0;
  logic        rst_i, start_i, test_button, busy_o;
  logic [7:0]  a_i, b_i;
  logic [12:0] y_o;

  int          total = 0;
  int          bad   = 0;
  logic [12:0] exp_q[$];
  string       name_q[$];
  logic        busy_prev = 1'b0;
  logic [7:0]  golden, la, lb, d;

  always #5 clk = ~clk;

  bist_logic_unit u_dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .start_i    (start_i),
    .test_button(test_button),
    .busy_o     (busy_o),
    .y_o        (y_o)
  );

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    total++;
    if (act < 1 || act > lim) begin
      bad++;
      $display("FAIL %s: got %0d, required 1..%0d", name, act, lim);
    end
  endtask

  function automatic logic [4:0] ref_y(input int a, input int b);
    int c = 0;
    int y = 0;
    for (int r = 0; r <= 6; r++) if (r * r * r <= b) c = r;
    for (int i = 0; i <= 16; i++) if (i * i <= a + c) y = i;
    return 5'(y);
  endfunction

  // Scoreboard monitor: every busy_o fall is a completed operation.
  always @(negedge clk) begin
    if (busy_prev && !busy_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got y_o=%h, required no completion", y_o);
      end else begin
        check(name_q.pop_front(), y_o, exp_q.pop_front());
      end
    end
    busy_prev <= busy_o;
  end

  task automatic wait_busy_low(input string name, input int limit);
    int n = 0;
    while (busy_o && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) check_int({name, "_timeout"}, n, -1);
  endtask

  task automatic run_user(input logic [7:0] a, input logic [7:0] b,
                          input logic [4:0] y, input string name);
    int  rises = 0;
    int  lat   = -1;
    logic pb   = 1'b0;
    @(negedge clk);
    a_i = a;
    b_i = b;
    exp_q.push_back({8'd0, y});
    name_q.push_back(name);
    start_i = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (busy_o && !pb) rises++;
      if (!busy_o && pb && lat < 0) lat = i;
      pb = busy_o;
    end
    start_i = 1'b0;
    check_int({name, "_ops"}, rises, 1);
    check_le({name, "_lat"}, lat, 32);
  endtask

  task automatic run_bist(input logic [3:0] k, input string name);
    int n = 0;
    @(negedge clk);
    exp_q.push_back({k, 1'b0, golden});
    name_q.push_back(name);
    start_i = 1'b1;
    while (!busy_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!busy_o) check_int({name, "_start_timeout"}, n, -1);
    wait_busy_low(name, 10000);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic press_button();
    @(negedge clk);
    test_button = 1'b1;
    repeat (100) @(negedge clk);
    test_button = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int n;
    int rises;
    la  = 8'hFF;
    lb  = 8'hA5;
    golden = 8'h00;
    for (int v = 0; v < 255; v++) begin
      d = {3'b000, ref_y(int'(la), int'(lb))};
      golden = golden ^ d;
      for (int k = 0; k < 8; k++)
        golden = golden[7] ? ((golden << 1) ^ 8'h07) : (golden << 1);
      la = {la[6:0], la[7] ^ la[5] ^ la[4] ^ la[3]};
      lb = {lb[6:0], lb[7] ^ lb[5] ^ lb[4] ^ lb[3]};
    end
    $display("reference signature %h", golden);

    rst_i = 1'b1; start_i = 1'b0; test_button = 1'b0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("reset_busy", {12'd0, busy_o}, 13'd0);
    check("reset_y", y_o, 13'd0);

    run_user(8'd0,   8'd0,   5'd0,  "u_0_0");
    run_user(8'd1,   8'd1,   5'd1,  "u_1_1");
    run_user(8'd12,  8'd60,  5'd3,  "u_12_60");
    run_user(8'd123, 8'd223, 5'd11, "u_123_223");
    run_user(8'd255, 8'd255, 5'd16, "u_255_255");
    run_user(8'd255, 8'd30,  5'd16, "u_255_30");
    run_user(8'd30,  8'd255, 5'd6,  "u_30_255");
    run_user(8'd1,   8'd255, 5'd2,  "u_1_255");
    run_user(8'd255, 8'd1,   5'd16, "u_255_1");
    run_user(8'd45,  8'd64,  5'd7,  "u_45_64");

    // A fresh start edge and new operands while busy must not disturb the result.
    @(negedge clk);
    a_i = 8'd45; b_i = 8'd64;
    exp_q.push_back(13'd7);
    name_q.push_back("busy_ignore");
    start_i = 1'b1;
    n = 0;
    while (!busy_o && n < 10) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    start_i = 1'b0; a_i = 8'd255; b_i = 8'd255;
    repeat (2) @(negedge clk);
    start_i = 1'b1;
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    wait_busy_low("busy_ignore", 100);
    rises = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy_o) rises++;
    end
    check_int("busy_ignore_no_rerun", rises, 0);

    press_button();
    run_bist(4'd1, "bist_run1");
    run_bist(4'd2, "bist_run2");
    run_bist(4'd3, "bist_run3");
    run_bist(4'd4, "bist_run4");

    press_button();
    run_user(8'd255, 8'd30, 5'd16, "user_after_bist");

    press_button();
    @(negedge clk);
    start_i = 1'b1;
    repeat (500) @(negedge clk);
    check("bist_midrun_busy", {12'd0, busy_o}, 13'd1);
    exp_q.push_back(13'd0);
    name_q.push_back("rst_abort");
    rst_i = 1'b1;
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_busy", {12'd0, busy_o}, 13'd0);
    check("rst_y", y_o, 13'd0);

    run_user(8'd123, 8'd223, 5'd11, "user_after_rst");
    press_button();
    run_bist(4'd1, "bist_after_rst");

    repeat (20) @(negedge clk);
    check_int("scoreboard_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
